// File: rtl/round_iter_pkg.sv
// Shared types and helpers for the iterative round controller.
// State encoding, default widths and the key-schedule rotate.
package round_iter_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 4;
  localparam int ROT_MAX_W  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // x must be zero above bit w-1; result is masked back to w bits
  function automatic logic [ROT_MAX_W-1:0] rotl(
    input logic [ROT_MAX_W-1:0] x,
    input int unsigned          w,
    input int unsigned          r
  );
    logic [ROT_MAX_W-1:0] m;
    m = (w >= ROT_MAX_W) ? '1 : ((ROT_MAX_W'(1) << w) - ROT_MAX_W'(1));
    return ((x << r) | (x >> (w - r))) & m;
  endfunction

endpackage

// File: rtl/round_iter_ctrl_if.sv
// Valid/ready input and output bundle of the round controller.
// master drives the block in, slave is the controller side.
interface round_iter_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 4
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] in_key;
  logic [CNT_W-1:0]  in_rounds;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic [CNT_W-1:0]  round_idx;

  modport master (
    output in_valid, in_data, in_key, in_rounds, out_ready,
    input  in_ready, out_valid, out_data, busy, round_idx
  );

  modport slave (
    input  in_valid, in_data, in_key, in_rounds, out_ready,
    output in_ready, out_valid, out_data, busy, round_idx
  );

endinterface

// File: rtl/round_down_counter.sv
// Loadable down-counter that saturates at zero.
// Flags the final round (cnt==1) and the empty state (cnt==0).
module round_down_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] d_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = d_i;
    else if (en_i && cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CNT_W'(1));
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/round_iter_ctrl.sv
// Iterative round controller: one XOR/rotate round per clock,
// block in over valid/ready, result out over valid/ready.
module round_iter_ctrl
  import round_iter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int ROT    = 1
) (
  input  logic clk,
  input  logic rst,
  round_iter_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] st_q, st_d;
  logic [DATA_W-1:0] rk_q, rk_d;
  logic [DATA_W-1:0] od_q, od_d;
  logic [CNT_W-1:0]  ridx_q, ridx_d;
  logic              cnt_load, cnt_en;
  logic              cnt_last, cnt_zero;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rk_rot;
  logic [DATA_W-1:0] st_next;

  round_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (cnt_load),
    .en_i   (cnt_en),
    .d_i    (bus.in_rounds),
    .cnt_o  (cnt),
    .last_o (cnt_last),
    .zero_o (cnt_zero)
  );

  assign rk_rot  = DATA_W'(rotl(ROT_MAX_W'(rk_q), DATA_W, ROT));
  assign st_next = st_q ^ rk_q;

  always_comb begin
    state_d  = state_q;
    st_d     = st_q;
    rk_d     = rk_q;
    od_d     = od_q;
    ridx_d   = ridx_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          st_d     = bus.in_data;
          rk_d     = bus.in_key;
          ridx_d   = '0;
          cnt_load = 1'b1;
          if (bus.in_rounds != '0) begin
            state_d = RUN;
          end else begin
            state_d = DONE;
            od_d    = bus.in_data;
          end
        end
      end
      RUN: begin
        st_d   = st_next;
        rk_d   = rk_rot;
        cnt_en = 1'b1;
        if (ridx_q != '1)
          ridx_d = ridx_q + CNT_W'(1);
        // zero is only a guard; a loaded RUN always ends via last
        if (cnt_last || cnt_zero) begin
          state_d = DONE;
          od_d    = st_next;
        end
      end
      DONE: begin
        if (bus.out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      st_q    <= '0;
      rk_q    <= '0;
      od_q    <= '0;
      ridx_q  <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      od_q    <= od_d;
      ridx_q  <= ridx_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == RUN) || (state_q == DONE);
  assign bus.out_data  = od_q;
  assign bus.round_idx = ridx_q;

  logic unused_cnt;
  assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_round_iter_ctrl.sv
// Directed plus random bench for round_iter_ctrl against a
// loop-based model of the XOR/rotate round sequence.
module tb_round_iter_ctrl;

  localparam int DW = 32;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  round_iter_ctrl_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  round_iter_ctrl #(.DATA_W(DW), .CNT_W(CW), .ROT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [DW-1:0] model(
    input logic [DW-1:0] d,
    input logic [DW-1:0] k,
    input int            n
  );
    logic [DW-1:0] s, r;
    s = d;
    r = k;
    for (int i = 0; i < n; i++) begin
      s = s ^ r;
      r = {r[DW-2:0], r[DW-1]};
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept_blk(input logic [DW-1:0] d,
                            input logic [DW-1:0] k, input int n);
    chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_key    = k;
    bus.in_rounds = CW'(n);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_data   = $urandom;
    bus.in_key    = $urandom;
    bus.in_rounds = CW'($urandom);
  endtask

  task automatic wait_done(input logic [DW-1:0] d,
                           input logic [DW-1:0] k, input int n);
    int lat;
    lat = 0;
    if (n > 0) begin
      chk("busy_run", 64'(bus.busy), 64'd1);
      chk("in_ready_run", 64'(bus.in_ready), 64'd0);
    end
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(n));
    chk("out_data", 64'(bus.out_data), 64'(model(d, k, n)));
    chk("round_idx", 64'(bus.round_idx), 64'(n));
    chk("busy_done", 64'(bus.busy), 64'd1);
  endtask

  task automatic drain(input logic [DW-1:0] exp, input int hold);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_data", 64'(bus.out_data), 64'(exp));
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("post_valid", 64'(bus.out_valid), 64'd0);
    chk("post_in_ready", 64'(bus.in_ready), 64'd1);
    chk("post_busy", 64'(bus.busy), 64'd0);
    chk("post_data", 64'(bus.out_data), 64'(exp));
  endtask

  task automatic check_reset_state();
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_idx", 64'(bus.round_idx), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
  endtask

  initial begin
    logic [DW-1:0] d, k;
    int n, h;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_key    = '0;
    bus.in_rounds = '0;
    bus.out_ready = 1'b0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

    accept_blk(32'h0, 32'h1, 3);
    wait_done(32'h0, 32'h1, 3);
    chk("basic_const", 64'(bus.out_data), 64'h7);
    drain(32'h7, 0);

    accept_blk(32'hDEADBEEF, 32'h12345678, 0);
    wait_done(32'hDEADBEEF, 32'h12345678, 0);
    drain(32'hDEADBEEF, 1);

    accept_blk(32'hF0F0F0F0, 32'h0F0F0F0F, 1);
    wait_done(32'hF0F0F0F0, 32'h0F0F0F0F, 1);
    chk("bp_const", 64'(bus.out_data), 64'hFFFFFFFF);
    drain(32'hFFFFFFFF, 5);

    accept_blk(32'h0, 32'h1, 15);
    wait_done(32'h0, 32'h1, 15);
    chk("max_const", 64'(bus.out_data), 64'h7FFF);
    drain(32'h7FFF, 2);

    accept_blk(32'hA5A5A5A5, 32'h3C3C3C3C, 10);
    repeat (4) @(negedge clk);
    chk("mid_idx", 64'(bus.round_idx), 64'd4);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", 64'(bus.in_ready), 64'd1);
    accept_blk(32'h13579BDF, 32'h2468ACE0, 6);
    wait_done(32'h13579BDF, 32'h2468ACE0, 6);
    drain(model(32'h13579BDF, 32'h2468ACE0, 6), 0);

    for (int t = 0; t < 25; t++) begin
      d = $urandom;
      k = $urandom;
      n = int'($urandom_range(0, 15));
      h = int'($urandom_range(0, 3));
      accept_blk(d, k, n);
      wait_done(d, k, n);
      drain(model(d, k, n), h);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/round_iter_ctrl.md
Name: round_iter_ctrl

Overview:
- Iterative round controller and datapath for the encryption core's multi-round stage.
- Accepts one data block, a key and a round count over a valid/ready handshake, then applies one round per clock.
- Presents the result over a valid/ready output handshake.
- Its internal round counter produces the iteration-done indication. The block plays the start/consume role around that iteration counting.

Parameters:
- DATA_W, 32: width of data block, key and round key.
- CNT_W, 4: width of the round count. Maximum rounds = 2^CNT_W-1.
- ROT, 1: left-rotate amount applied to the round key after each round. Must satisfy 0 < ROT < DATA_W.

Ports:
- clk  in  1  Single clock. All logic is on the rising edge.
- rst  in  1  Synchronous, active-high reset.
- in_valid  in  1  Upstream offers in_data/in_key/in_rounds.
- in_ready  out  1  Block accepts input. High only in IDLE and not in reset.
- in_data  in  DATA_W  Plaintext block.
- in_key  in  DATA_W  Initial round key.
- in_rounds  in  CNT_W  Number of rounds N to apply.
- out_valid  out  1  out_data holds a finished result.
- out_ready  in  1  Downstream consumes the result.
- out_data  out  DATA_W  Result block.
- busy  out  1  High in RUN or DONE.
- round_idx  out  CNT_W  Rounds completed for the current block.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - out_valid=0, out_data=0, busy=0, round_idx=0; internal state/key/count registers are 0.
  - in_ready=0 while rst is high.
  - Reset overrides everything, including mid-RUN or DONE. Any in-flight block is discarded with no output.
- States are IDLE, RUN and DONE, encoded as a 2-bit enum. The unused encoding returns to IDLE.
- IDLE:
  - in_ready=1.
  - On accept (in_valid && in_ready): st <= in_data, rk <= in_key, cnt <= in_rounds, round_idx <= 0.
  - If in_rounds != 0, go to RUN. Otherwise go to DONE with out_data <= in_data (pass-through).
- RUN, each edge performs one round:
  - st <= st ^ rk; rk <= rotl(rk, ROT); cnt <= cnt-1; round_idx <= round_idx+1.
  - When cnt==1 at the edge, the round still executes and the state goes to DONE. out_data is loaded with the post-round value on that same edge.
- DONE:
  - out_valid=1 and out_data is held stable.
  - On out_valid && out_ready, go to IDLE and out_valid drops next cycle. out_data retains its value until the next load.
  - out_valid must not drop without a handshake.
- Latency:
  - out_valid rises on the N-th edge after the accepting edge. For N=0 it rises on the accepting edge itself.
  - Throughput is one block per N+2 cycles minimum, because there is no overlap of input and output.
- in_ready is low in RUN and DONE. in_valid in those states is ignored, and held inputs are not sampled.
- Arithmetic:
  - XOR and rotate are full width modulo DATA_W; there is no carry.
  - cnt never underflows: its decrement is only enabled when cnt != 0.
  - round_idx saturates at 2^CNT_W-1, which is reachable only at N max.
- N = 2^CNT_W-1 (15) runs 15 rounds exactly.
- Simultaneous out handshake in DONE and in_valid: no accept that cycle. The next block is accepted no earlier than the cycle after returning to IDLE.

Decomposition:
- Package round_iter_pkg holds:
  - state enum typedef (IDLE, RUN, DONE);
  - default DATA_W/CNT_W localparams;
  - rotl function (parameterised by ROT).
- One sub-module, round_down_counter:
  - loadable CNT_W down-counter with load, en, sync active-high rst;
  - saturates at 0;
  - last output = (cnt==1) and zero output = (cnt==0).
  - The FSM uses last for the RUN->DONE transition.

Test Plan:
- Reset then idle: rst high 2 cycles -> out_valid=0, out_data=0, busy=0, round_idx=0, in_ready=0 during rst and 1 the cycle after.
- Basic 3 rounds, DATA_W=32, ROT=1: in_data=0, in_key=1, in_rounds=3 accepted at edge E -> out_valid high after E+3, out_data=0x00000007, round_idx=3, busy=1 through DONE.
- Zero rounds: in_data=0xDEADBEEF, in_key=0x12345678, in_rounds=0 -> out_valid after accepting edge, out_data=0xDEADBEEF, round_idx=0.
- Output backpressure: 1 round, in_data=0xF0F0F0F0, in_key=0x0F0F0F0F, out_ready low 5 cycles -> out_data=0xFFFFFFFF held stable with out_valid=1 and in_ready=0. A new in_valid is ignored; after out_ready, IDLE and in_ready=1 next cycle.
- Max rounds: in_data=0, in_key=1, in_rounds=15 -> result 0x00007FFF after exactly 15 edges, round_idx=15, no counter underflow.
- Reset mid-RUN: in_rounds=10, rst asserted after round 4 -> next cycle IDLE, out_valid=0, round_idx=0. A fresh block afterwards completes with correct value.
